// File: rtl/bpf_forwarder.sv
// bpf_forwarder: streams a filtered packet out of packet memory
// onto a 64-bit AXI-Stream, then hands the buffer back.
module bpf_forwarder #(
    parameter int PACKET_BYTE_ADDR_WIDTH = 12,
    parameter int PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ready_for_forwarder,
    input  logic [PACKET_BYTE_ADDR_WIDTH:0] packet_len,
    output logic [PACKET_ADDR_WIDTH-1:0]    forwarder_rd_addr,
    output logic                            forwarder_rd_en,
    input  logic [63:0]                     forwarder_rd_data,
    output logic                            forwarder_done,
    output logic [63:0]                     m_tdata,
    output logic [7:0]                      m_tkeep,
    output logic                            m_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready
);
    localparam int BW = PACKET_BYTE_ADDR_WIDTH - 2;
    localparam int LW = PACKET_BYTE_ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, STREAM, DONE, WAIT_LOW} state_e;

    state_e          state_q, state_d;
    logic [1:0]      rst_sync_q;
    logic            rst_n;
    logic [BW-1:0]   beats_q, beats_d;
    logic [BW-1:0]   issued_q;
    logic [7:0]      last_keep_q, last_keep_d;
    logic [LW-1:0]   len_pad;
    logic            infl_q, infl_last_q;
    logic [7:0]      infl_keep_q;
    logic [63:0]     data_q [2];
    logic [7:0]      keep_q [2];
    logic            last_q [2];
    logic [1:0]      cnt_q;
    logic            wr_ptr_q, rd_ptr_q;
    logic            pop, head_last, room, issue_last;
    logic [2:0]      credit;

    assign rst_n = rst_sync_q[1];

    assign len_pad     = {1'b0, packet_len} + LW'(7);
    assign beats_d     = BW'(len_pad >> 3);
    assign last_keep_d = (packet_len[2:0] == 3'd0) ? 8'hFF
                       : ~(8'hFF >> packet_len[2:0]);

    assign m_tvalid  = (cnt_q != 2'd0);
    assign pop       = m_tvalid && m_tready;
    assign head_last = last_q[rd_ptr_q];
    assign m_tdata   = m_tvalid ? data_q[rd_ptr_q] : 64'd0;
    assign m_tkeep   = m_tvalid ? keep_q[rd_ptr_q] : 8'd0;
    assign m_tlast   = m_tvalid && head_last;

    // A beat popped this cycle frees its slot for a read issued this cycle
    assign credit     = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    assign room       = (credit < 3'd2);
    assign issue_last = (issued_q == beats_q - BW'(1));

    assign forwarder_rd_addr = forwarder_rd_en
                             ? PACKET_ADDR_WIDTH'({issued_q, 1'b0})
                             : '0;

    // Assert asynchronously, release on the second clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (ready_for_forwarder)
                          state_d = (packet_len == '0) ? DONE : STREAM;
            STREAM:   if (pop && head_last) state_d = DONE;
            DONE:     state_d = WAIT_LOW;
            WAIT_LOW: if (!ready_for_forwarder) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs: read strobe and buffer release
    always_comb begin
        forwarder_rd_en = 1'b0;
        forwarder_done  = 1'b0;
        unique case (state_q)
            STREAM:  forwarder_rd_en = room && (issued_q != beats_q);
            DONE:    forwarder_done  = 1'b1;
            default: ;
        endcase
    end

    // Latch packet geometry on accept, then count issued reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q     <= '0;
            last_keep_q <= '0;
            issued_q    <= '0;
        end else if (state_q == IDLE && ready_for_forwarder) begin
            beats_q     <= beats_d;
            last_keep_q <= last_keep_d;
            issued_q    <= '0;
        end else if (forwarder_rd_en) begin
            issued_q <= issued_q + BW'(1);
        end
    end

    // Track the read in flight with the sideband its beat will carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q      <= 1'b0;
            infl_keep_q <= '0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q      <= forwarder_rd_en;
            infl_keep_q <= issue_last ? last_keep_q : 8'hFF;
            infl_last_q <= issue_last;
        end
    end

    // Two-entry output FIFO fed by returning read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                keep_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (infl_q) begin
                data_q[wr_ptr_q] <= forwarder_rd_data;
                keep_q[wr_ptr_q] <= infl_keep_q;
                last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bpf_forwarder.sv
// tb_bpf_forwarder: randomized scoreboard bench for bpf_forwarder
// against a byte-level packet model.
module tb_bpf_forwarder;
    localparam int BA = 12;
    localparam int AW = BA - 2;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready_for_forwarder = 1'b0;
    logic [BA:0]   packet_len = '0;
    logic [AW-1:0] forwarder_rd_addr;
    logic          forwarder_rd_en;
    logic [63:0]   forwarder_rd_data = '0;
    logic          forwarder_done;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b0;

    beat_t       exp_q[$];
    logic [63:0] mem [512];
    int checks = 0;
    int errors = 0;
    int rmode = 0;
    int cur_len = 0;
    int cur_beats = 0;
    int done_seen = 0;
    int popped = 0;
    int last_addr = -1;

    int    cyc = 0;
    int    exp_addr = 0;
    int    outstanding = 0;
    int    last_hs_cyc = 0;
    bit    pend_v = 1'b0;
    int    pend_addr = 0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;

    bpf_forwarder #(.PACKET_BYTE_ADDR_WIDTH(BA)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ready_for_forwarder (ready_for_forwarder),
        .packet_len          (packet_len),
        .forwarder_rd_addr   (forwarder_rd_addr),
        .forwarder_rd_en     (forwarder_rd_en),
        .forwarder_rd_data   (forwarder_rd_data),
        .forwarder_done      (forwarder_done),
        .m_tdata             (m_tdata),
        .m_tkeep             (m_tkeep),
        .m_tlast             (m_tlast),
        .m_tvalid            (m_tvalid),
        .m_tready            (m_tready)
    );

    always #5 clk = ~clk;

    // Sink backpressure pattern
    always @(posedge clk) begin
        #2;
        case (rmode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Memory responder and output monitor
    always @(negedge clk) begin
        beat_t got;
        beat_t e;
        cyc++;
        got = {m_tdata, m_tkeep, m_tlast};
        forwarder_rd_data = pend_v ? mem[pend_addr] : {$urandom, $urandom};
        pend_v    = forwarder_rd_en;
        pend_addr = int'(forwarder_rd_addr >> 1);
        if (!rst) begin
            exp_addr    = 0;
            outstanding = 0;
            pend_v      = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_tvalid || got != prev_beat) begin
                    errors++;
                    $display("FAIL stall_stable got v=%b %h/%h/%b required %h/%h/%b",
                             m_tvalid, got.data, got.keep, got.last,
                             prev_beat.data, prev_beat.keep, prev_beat.last);
                end
            end
            if (forwarder_rd_en) begin
                checks++;
                if (forwarder_rd_addr != AW'(exp_addr) || exp_addr / 2 >= cur_beats) begin
                    errors++;
                    $display("FAIL rd_addr got %0d required %0d (beats %0d)",
                             forwarder_rd_addr, exp_addr, cur_beats);
                end
                last_addr = int'(forwarder_rd_addr);
                exp_addr += 2;
                outstanding++;
            end
            if (m_tvalid && m_tready) begin
                outstanding--;
                popped++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got %h/%h/%b required none",
                             got.data, got.keep, got.last);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        errors++;
                        $display("FAIL beat got %h/%h/%b required %h/%h/%b",
                                 got.data, got.keep, got.last, e.data, e.keep, e.last);
                    end
                    if (e.last) last_hs_cyc = cyc;
                end
            end
            if (forwarder_rd_en) begin
                checks++;
                if (outstanding > 2) begin
                    errors++;
                    $display("FAIL credit got %0d required <=2", outstanding);
                end
            end
            if (forwarder_done) begin
                done_seen++;
                exp_addr = 0;
                if (cur_len != 0) begin
                    checks++;
                    if (cyc != last_hs_cyc + 1) begin
                        errors++;
                        $display("FAIL done_timing got cycle %0d required %0d",
                                 cyc, last_hs_cyc + 1);
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = got;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"},   64'(forwarder_rd_en),   64'd0);
        chk({tag, "_rd_addr"}, 64'(forwarder_rd_addr), 64'd0);
        chk({tag, "_done"},    64'(forwarder_done),    64'd0);
        chk({tag, "_tvalid"},  64'(m_tvalid),          64'd0);
        chk({tag, "_tlast"},   64'(m_tlast),           64'd0);
        chk({tag, "_tkeep"},   64'(m_tkeep),           64'd0);
        chk({tag, "_tdata"},   m_tdata,                64'd0);
    endtask

    // Reference model: byte-level slicing of the packet into beats
    task automatic push_expected(input int len);
        int beats;
        int nb;
        logic [7:0] keep;
        beat_t b;
        beats = (len + 7) / 8;
        for (int k = 0; k < beats; k++) begin
            nb = len - 8 * k;
            if (nb > 8) nb = 8;
            keep = 8'h00;
            for (int i = 0; i < nb; i++) keep[7 - i] = 1'b1;
            b = '{data: mem[k], keep: keep, last: (k == beats - 1)};
            exp_q.push_back(b);
        end
    endtask

    task automatic fill_mem(input int beats);
        for (int k = 0; k < beats; k++) mem[k] = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int d0, input int beats);
        int n;
        n = 0;
        while (done_seen == d0 && n < 8 * beats + 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (done_seen == d0) begin
            errors++;
            $display("FAIL done_timeout got no done required one within %0d cycles", n);
        end
    endtask

    task automatic run_pkt(input int len, input int mode, input bit custom,
                           input logic [63:0] w0, input bit drop_early);
        int  beats;
        int  d0;
        int  n;
        bit  seen;
        beats = (len + 7) / 8;
        fill_mem(beats);
        if (custom) mem[0] = w0;
        push_expected(len);
        rmode     = mode;
        cur_len   = len;
        cur_beats = beats;
        d0        = done_seen;
        @(posedge clk);
        #2;
        ready_for_forwarder = 1'b1;
        packet_len = (BA + 1)'(len);
        if (len != 0) begin
            n = 0;
            seen = 1'b0;
            while (!seen && n < 10) begin
                @(posedge clk);
                #1;
                n++;
                seen = m_tvalid;
            end
            checks++;
            if (!seen || n != 3) begin
                errors++;
                $display("FAIL latency got %0d edges (seen %b) required 3", n, seen);
            end
            #1;
            packet_len = (BA + 1)'($urandom);
            if (drop_early) ready_for_forwarder = 1'b0;
        end
        wait_done(d0, beats);
        if (len == 0) repeat (10) @(posedge clk);
        @(posedge clk);
        #2;
        ready_for_forwarder = 1'b0;
        packet_len = (BA + 1)'($urandom);
        repeat (6) @(posedge clk);
        chk("done_count", 64'(done_seen - d0), 64'd1);
        chk("leftover",   64'(exp_q.size()),   64'd0);
        if (len != 0) chk("last_addr", 64'(last_addr), 64'(2 * (beats - 1)));
    endtask

    task automatic reset_mid_stream();
        int d0;
        int p0;
        int n;
        fill_mem(7);
        push_expected(56);
        rmode     = 0;
        cur_len   = 56;
        cur_beats = 7;
        d0 = done_seen;
        p0 = popped;
        @(posedge clk);
        #2;
        ready_for_forwarder = 1'b1;
        packet_len = (BA + 1)'(56);
        n = 0;
        while (popped - p0 < 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("abort_beats", 64'(popped - p0 >= 3), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        push_expected(56);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        wait_done(d0, 7);
        @(posedge clk);
        #2;
        ready_for_forwarder = 1'b0;
        repeat (6) @(posedge clk);
        chk("resend_done_count", 64'(done_seen - d0), 64'd1);
        chk("resend_leftover",   64'(exp_q.size()),   64'd0);
        chk("resend_last_addr",  64'(last_addr),      64'd12);
    endtask

    initial begin
        #3;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (4) @(posedge clk);

        run_pkt(56, 0, 1'b0, 64'd0, 1'b0);
        run_pkt(54, 0, 1'b1, 64'h70b31760a09f782b, 1'b0);
        run_pkt(56, 1, 1'b0, 64'd0, 1'b0);
        run_pkt(0, 0, 1'b0, 64'd0, 1'b0);
        reset_mid_stream();
        run_pkt(1, 2, 1'b0, 64'd0, 1'b0);
        run_pkt(8, 2, 1'b0, 64'd0, 1'b1);
        run_pkt(9, 1, 1'b0, 64'd0, 1'b1);
        for (int t = 0; t < 6; t++)
            run_pkt($urandom_range(1, 300), 2, 1'b0, 64'd0, t[0]);
        run_pkt(4096, 2, 1'b0, 64'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpf_forwarder.md
BPF_FORWARDER -- requirements
Module: bpf_forwarder

Interface
REQ-001 SHALL have parameter PACKET_BYTE_ADDR_WIDTH, default 12, packet memory byte-address width.
REQ-002 SHALL have parameter PACKET_ADDR_WIDTH, default PACKET_BYTE_ADDR_WIDTH-2, 32-bit-word address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port ready_for_forwarder  input  1  level; a filtered packet is in memory and owned by this block.
REQ-006 SHALL have port packet_len  input  PACKET_BYTE_ADDR_WIDTH+1  packet length in bytes; valid while ready_for_forwarder=1.
REQ-007 SHALL have port forwarder_rd_addr  output  PACKET_ADDR_WIDTH  32-bit-word read address, always even.
REQ-008 SHALL have port forwarder_rd_en  output  1  read strobe.
REQ-009 SHALL have port forwarder_rd_data  input  64  read data, valid exactly 1 cycle after forwarder_rd_en.
REQ-010 SHALL have port forwarder_done  output  1  single-cycle pulse that releases the memory buffer.
REQ-011 SHALL have ports m_tdata output 64, m_tkeep output 8, m_tlast output 1, m_tvalid output 1, m_tready input 1: output stream.

Function
REQ-012 SHALL implement states IDLE, STREAM, DONE, WAIT_LOW.
REQ-013 IDLE: on ready_for_forwarder=1 SHALL latch packet_len, compute beats=ceil(packet_len/8), set read pointer to 0, go to STREAM; if packet_len=0, go directly to DONE.
REQ-014 STREAM: SHALL assert forwarder_rd_en with forwarder_rd_addr=2*beat_index only when (buffer occupancy + reads in flight) < 2 and reads issued < beats.
REQ-015 SHALL capture forwarder_rd_data into a 2-entry FIFO one cycle after each forwarder_rd_en; no read data SHALL ever be dropped.
REQ-016 m_tvalid SHALL equal FIFO not-empty; the head beat SHALL pop when m_tvalid && m_tready.
REQ-017 m_tdata, m_tkeep, m_tlast SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-018 Byte order: packet byte 8k+i SHALL appear on m_tdata[63-8i:56-8i]; m_tkeep[7-i] marks it valid.
REQ-019 m_tkeep SHALL be 8'hFF on every beat except the last; on the last beat it SHALL have the top (packet_len mod 8) bits set, or all 8 bits if that remainder is 0.
REQ-020 m_tlast SHALL be 1 only on beat beats-1.
REQ-021 With m_tready held at 1, throughput SHALL be one beat per cycle after the first; first m_tvalid SHALL occur 2 cycles after the IDLE->STREAM transition.
REQ-022 STREAM->DONE SHALL occur on the cycle the last beat handshakes.
REQ-023 DONE SHALL assert forwarder_done for exactly one cycle, then go to WAIT_LOW.
REQ-024 WAIT_LOW SHALL return to IDLE when ready_for_forwarder=0, so one ready level is never forwarded twice.
REQ-025 Changes on packet_len after latching SHALL be ignored.
REQ-026 Deassertion of ready_for_forwarder during STREAM SHALL be ignored; the packet completes.
REQ-027 Maximum packet_len 2^PACKET_BYTE_ADDR_WIDTH (4096) SHALL yield 512 beats; rd_addr SHALL not wrap within a packet.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, FIFO empty, in-flight cleared, and all outputs 0: forwarder_rd_en, forwarder_rd_addr, forwarder_done, m_tvalid, m_tlast, m_tkeep, m_tdata.
REQ-029 Reset mid-STREAM SHALL abort the packet with no forwarder_done; after release, if ready_for_forwarder=1, the packet SHALL be resent from beat 0.
REQ-030 Reset SHALL release synchronously to clk inside the block (2-flop deassert synchronizer).

Verification
REQ-031 packet_len=56, m_tready=1 -> rd_addr 0,2,...,12; 7 beats on consecutive cycles; last beat tkeep=FF, tlast=1; done pulses 1 cycle after the last beat.
REQ-032 packet_len=54 -> 7 beats; last beat tkeep=8'hFC; memory word 0x70b31760a09f782b is the first tdata.
REQ-033 m_tready toggled 1/0 per cycle -> no lost or duplicated beat; data stable while stalled; occupancy+in-flight never exceeds 2.
REQ-034 packet_len=0 -> no rd_en, no m_tvalid; done pulses once; ready held high for 10 cycles -> no second done.
REQ-035 rst=0 at beat 3 of 7 -> outputs 0 immediately; ready still 1 after release -> full 7-beat resend, single done.
REQ-036 packet_len=4096, random m_tready -> 512 beats, final rd_addr 1022, tlast only on beat 511.
